// File: rtl/raisin64_pkg.sv
// Shared definitions for the raisin64 front end: datapath width, fetch stride,
// fetch FSM encoding and the buffered-instruction record.
package raisin64_pkg;

    localparam int          XLEN         = 64;
    localparam logic [63:0] FETCH_STRIDE = 64'd8;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: circular FIFO with push/pop/flush, head read straight
// from storage so there is no bypass from the write port.
module ifetch_fifo
    import raisin64_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop; flush wins over both.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (flush) begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end else begin
            push_ok_s = push & ~full;
            pop_ok_s  = pop & ~empty;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else if (flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding memory request, redirect/flush handling
// and a small buffer feeding decode.
module ifetch
    import raisin64_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    output logic        imem_addr_valid,
    input  logic [63:0] imem_data,
    input  logic        imem_data_valid,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] if_inst,
    output logic [63:0] if_pc,
    output logic        if_valid,
    input  logic        id_ready
);

    localparam logic [63:0] RESET_PC_A = align_pc(RESET_PC);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [63:0]  fetch_pc_r;
    logic [63:0]  req_pc_r;
    logic         issue_s;
    logic         push_s;
    logic         pop_s;
    logic         fifo_full_s;
    logic         fifo_empty_s;
    fetch_entry_t push_entry_s;
    fetch_entry_t head_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; a response arriving with a redirect still retires the request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (issue_s) state_nxt_s = ST_WAIT;
                else         state_nxt_s = ST_RUN;
            end
            ST_WAIT: begin
                if (imem_data_valid) state_nxt_s = ST_RUN;
                else if (redirect)   state_nxt_s = ST_DROP;
                else                 state_nxt_s = ST_WAIT;
            end
            ST_DROP: begin
                if (imem_data_valid) state_nxt_s = ST_RUN;
                else                 state_nxt_s = ST_DROP;
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM outputs; rst_n gates issue so no request strobes during reset.
    always_comb begin
        issue_s = 1'b0;
        push_s  = 1'b0;
        case (state_r)
            ST_RUN:  issue_s = rst_n & ~redirect & ~fifo_full_s;
            ST_WAIT: push_s  = imem_data_valid & ~redirect;
            ST_DROP: push_s  = 1'b0;
            default: issue_s = 1'b0;
        endcase
        pop_s = ~fifo_empty_s & id_ready & ~redirect;
    end

    // Fetch PC and the PC of the request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC_A;
            req_pc_r   <= RESET_PC_A;
        end else begin
            if (redirect)    fetch_pc_r <= align_pc(redirect_pc);
            else if (push_s) fetch_pc_r <= req_pc_r + FETCH_STRIDE;
            else             fetch_pc_r <= fetch_pc_r;
            if (issue_s)     req_pc_r   <= fetch_pc_r;
            else             req_pc_r   <= req_pc_r;
        end
    end

    assign push_entry_s = '{pc: req_pc_r, inst: imem_data};

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redirect),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign imem_addr       = fetch_pc_r;
    assign imem_addr_valid = issue_s;
    assign if_valid        = ~fifo_empty_s;
    assign if_pc           = head_s.pc;
    assign if_inst         = head_s.inst;

endmodule
